// File: rtl/sargantana_icache_pkg.sv
// ============================================================================
// Module      : sargantana_icache_pkg
// Description : Shared types and default sizes for the instruction-cache
//               line-refill engine.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sargantana_icache_pkg;

  localparam int ICACHE_REFILL_BEATS = 4;
  localparam int ICACHE_BEAT_WIDTH   = 128;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    COLLECT = 3'd2,
    RESP    = 3'd3,
    DRAIN   = 3'd4
  } refill_state_t;

endpackage

`default_nettype wire

// File: rtl/sargantana_icache_refill_if.sv
// ============================================================================
// Module      : sargantana_icache_refill_if
// Description : IFILL request/response and memory read channels of the
//               line-refill engine.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface sargantana_icache_refill_if #(
  parameter int PADDR_LINE_W = 34,
  parameter int BEAT_W       = 128,
  parameter int N_BEATS      = 4,
  parameter int WAY_W        = 2
);

  logic                        ifill_req_valid_i;
  logic [PADDR_LINE_W-1:0]     ifill_req_paddr_i;
  logic [WAY_W-1:0]            ifill_req_way_i;
  logic                        kill_i;
  logic                        ifill_ready_o;
  logic                        ifill_resp_valid_o;
  logic [BEAT_W*N_BEATS-1:0]   ifill_resp_data_o;
  logic [WAY_W-1:0]            ifill_resp_way_o;
  logic                        mem_req_valid_o;
  logic [PADDR_LINE_W-1:0]     mem_req_addr_o;
  logic                        mem_req_ready_i;
  logic                        mem_resp_valid_i;
  logic [BEAT_W-1:0]           mem_resp_data_i;
  logic                        err_o;

  // Environment side: the cache plus the next memory level.
  modport master (
    output ifill_req_valid_i, ifill_req_paddr_i, ifill_req_way_i, kill_i,
    output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    input  ifill_ready_o, ifill_resp_valid_o, ifill_resp_data_o, ifill_resp_way_o,
    input  mem_req_valid_o, mem_req_addr_o, err_o
  );

  // Refill engine side.
  modport slave (
    input  ifill_req_valid_i, ifill_req_paddr_i, ifill_req_way_i, kill_i,
    input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    output ifill_ready_o, ifill_resp_valid_o, ifill_resp_data_o, ifill_resp_way_o,
    output mem_req_valid_o, mem_req_addr_o, err_o
  );

endinterface

`default_nettype wire

// File: rtl/sargantana_icache_refill.sv
// ============================================================================
// Module      : sargantana_icache_refill
// Description : Single-outstanding line-refill engine; assembles memory beats
//               into a cache line and drains reads abandoned by a kill.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sargantana_icache_refill
  import sargantana_icache_pkg::*;
#(
  parameter int PADDR_LINE_W = 34,
  parameter int BEAT_W       = ICACHE_BEAT_WIDTH,
  parameter int N_BEATS      = ICACHE_REFILL_BEATS,
  parameter int WAY_W        = 2
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_i,
  sargantana_icache_refill_if.slave  bus
);

  localparam int              CNT_W     = $clog2(N_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  refill_state_t            state;
  refill_state_t            state_d;
  logic [CNT_W-1:0]         beat_cnt;
  logic                     kill_pend;
  logic                     err_q;
  logic [PADDR_LINE_W-1:0]  paddr_q;
  logic [WAY_W-1:0]         way_q;
  logic [BEAT_W-1:0]        line_q [N_BEATS];

  logic                     accept;
  logic                     last_beat;
  logic                     collect_beat;
  logic                     count_beat;
  logic [N_BEATS-1:0]       beat_we;

  assign accept    = (state == IDLE) && bus.ifill_req_valid_i && !bus.kill_i;
  assign last_beat = (beat_cnt == LAST_BEAT);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) state_d = REQ;
      end
      REQ: begin
        if (bus.mem_req_ready_i) state_d = (kill_pend || bus.kill_i) ? DRAIN : COLLECT;
      end
      COLLECT: begin
        // A kill landing on the final beat leaves nothing to drain.
        if (bus.mem_resp_valid_i && last_beat) state_d = bus.kill_i ? IDLE : RESP;
        else if (bus.kill_i)                   state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.mem_resp_valid_i && last_beat) state_d = IDLE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.ifill_ready_o      = 1'b0;
    bus.mem_req_valid_o    = 1'b0;
    bus.ifill_resp_valid_o = 1'b0;
    collect_beat           = 1'b0;
    count_beat             = 1'b0;
    case (state)
      IDLE:    bus.ifill_ready_o      = 1'b1;
      REQ:     bus.mem_req_valid_o    = 1'b1;
      COLLECT: begin
        collect_beat = bus.mem_resp_valid_i;
        count_beat   = bus.mem_resp_valid_i;
      end
      DRAIN:   count_beat             = bus.mem_resp_valid_i;
      RESP:    bus.ifill_resp_valid_o = !bus.kill_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt  <= '0;
      kill_pend <= 1'b0;
      err_q     <= 1'b0;
      paddr_q   <= '0;
      way_q     <= '0;
    end else begin
      if (accept) begin
        beat_cnt  <= '0;
        kill_pend <= 1'b0;
        paddr_q   <= bus.ifill_req_paddr_i;
        way_q     <= bus.ifill_req_way_i;
      end else if (count_beat) begin
        beat_cnt  <= beat_cnt + 1'b1;
      end
      if ((state == REQ) && bus.kill_i) kill_pend <= 1'b1;
      // Beats with no read outstanding are a memory-side protocol slip.
      if (bus.mem_resp_valid_i && ((state == IDLE) || (state == REQ))) err_q <= 1'b1;
    end
  end

  assign beat_we = collect_beat ? (N_BEATS'(1) << beat_cnt) : '0;

  for (genvar k = 0; k < N_BEATS; k++) begin : g_line_beat
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        line_q[k] <= '0;
      end else if (beat_we[k]) begin
        line_q[k] <= bus.mem_resp_data_i;
      end
    end
    assign bus.ifill_resp_data_o[k*BEAT_W +: BEAT_W] = line_q[k];
  end

  assign bus.mem_req_addr_o   = paddr_q;
  assign bus.ifill_resp_way_o = way_q;
  assign bus.err_o            = err_q;

endmodule

`default_nettype wire

// File: doc/sargantana_icache_refill.md
# sargantana_icache_refill

Line-refill engine between the instruction cache's IFILL port and the next memory level. Accepts one line-fill request at a time and issues a single line read. It collects the returned data beats into a full cache line and hands the line back to the cache as a one-cycle fill response. Kills arriving mid-refill are absorbed by draining the outstanding read, so the cache never sees stale data.

## Interface
Parameters:
- PADDR_LINE_W, 34: physical line address width (tag + index, no offset).
- BEAT_W, 128: memory data beat width.
- N_BEATS, 4: beats per line; power of two, at least 2.
- WAY_W, 2: way-select width.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ifill_req_valid_i  in  1  line-fill request from the cache.
- ifill_req_paddr_i  in  PADDR_LINE_W  line address of the request.
- ifill_req_way_i  in  WAY_W  victim way of the request.
- kill_i  in  1  abandon the current request; same-cycle effect.
- ifill_ready_o  out  1  high when the engine can accept a request.
- ifill_resp_valid_o  out  1  one-cycle pulse: full line delivered.
- ifill_resp_data_o  out  BEAT_W*N_BEATS  assembled line; beat k occupies bits [k*BEAT_W +: BEAT_W].
- ifill_resp_way_o  out  WAY_W  way captured at request accept.
- mem_req_valid_o  out  1  line read request to memory.
- mem_req_addr_o  out  PADDR_LINE_W  line address of the memory read.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_resp_valid_i  in  1  data beat valid; the engine never backpressures.
- mem_resp_data_i  in  BEAT_W  beat data, in order, beat 0 first.
- err_o  out  1  sticky protocol error flag.

## Operation
States and transitions:
- IDLE: ifill_ready_o=1. On ifill_req_valid_i && !kill_i, capture paddr and way, clear the beat counter, go to REQ.
- REQ: mem_req_valid_o=1, address taken from the captured register.
  - Valid stays high until mem_req_ready_i; it is never withdrawn.
  - On handshake, go to COLLECT, or to DRAIN if a kill is pending (kill seen in REQ or in the handshake cycle).
- COLLECT: each mem_resp_valid_i writes the beat into line-buffer slot beat_cnt and increments beat_cnt.
  - The beat counter is $clog2(N_BEATS) bits and wraps to 0 after the last beat.
  - On the last beat (beat_cnt==N_BEATS-1), go to RESP.
  - kill_i goes to DRAIN; the beat arriving in that same cycle is counted.
- DRAIN: consume and count the remaining beats without a response. Return to IDLE after the last beat.
- RESP: ifill_resp_valid_o = !kill_i, for one cycle, then go to IDLE.

Data and error rules:
- Data and way outputs hold their last values outside RESP.
- mem_resp_valid_i in IDLE or REQ sets err_o; the beat is ignored. err_o clears only on reset.
- A request arriving while not in IDLE is not accepted. The cache holds it until ifill_ready_o.

## Timing
Reset values:
- State IDLE, beat_cnt 0, pending-kill 0, err_o 0.
- mem_req_valid_o 0, ifill_resp_valid_o 0, ifill_ready_o 1.
- Data, address and way registers 0.

Latency and throughput:
- Accept at cycle 0, so mem_req_valid_o is high from cycle 1.
- With ready in cycle 1 and beats in cycles 2..(1+N_BEATS), ifill_resp_valid_o is high in cycle 2+N_BEATS.
- Next accept is possible in cycle 3+N_BEATS. No back-to-back overlap.

Boundary rules:
- Kill in the same cycle as the request in IDLE: the request is not accepted.
- Kill in the RESP cycle: the response is suppressed and the state returns to IDLE.
- Reset mid-refill clears all state immediately. Beats still in flight afterwards set err_o (reset does not hide memory-side protocol slips).

## Structure
- Package sargantana_icache_pkg gains:
  - refill_state_t enum (IDLE, REQ, COLLECT, RESP, DRAIN).
  - Default constants ICACHE_REFILL_BEATS and ICACHE_BEAT_WIDTH.
- Single module, no sub-modules. The line buffer is N_BEATS registers of BEAT_W bits, with a write enable per beat.

## Test plan
- Clean refill, N_BEATS=4: request paddr 0x2_0000_0040, way 2; ready immediate; beats 0xA0..0xA3 on consecutive cycles.
  - Expect resp_valid exactly once, 6 cycles after accept.
  - Expect data with 0xA3 in the top beat and 0xA0 in the bottom, way 2.
- Memory stalls: hold mem_req_ready_i low for 5 cycles, insert 3-cycle gaps between beats.
  - Expect mem_req_valid_o held high for all 5 stall cycles with the address unchanged.
  - Expect the response one cycle after the 4th beat.
- Kill in COLLECT after beat 1: expect no resp_valid and ifill_ready_o low until beat 3 is consumed.
  - A following request then fills correctly with fresh data.
- Kill in REQ before ready: expect mem_req_valid_o held until ready, then all 4 beats drained, no response, err_o stays 0.
- Kill in the RESP cycle: expect resp_valid 0 and state back in IDLE on the next cycle.
- Stray beat in IDLE: expect err_o=1 and sticky, with no response. Reset asserted mid-COLLECT returns ifill_ready_o to 1 asynchronously.
